// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: serially builds a 32-bit thermometer word holding the requested number of ones.
// Optional popcount self-check on the finished word when ONES_PATTERN_SELFCHECK_EN is defined.
module ones_pattern_gen #(
  parameter int DIV   = 10,
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ones_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pattern_out,
  output logic [5:0]       zeros_out,
  output logic             busy,
  output logic [3:0]       tick_count,
  output logic [5:0]       bit_idx
`ifdef ONES_PATTERN_SELFCHECK_EN
  ,
  output logic             check_err
`endif
);
  typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;
  localparam logic [3:0] TMAX = 4'(DIV - 1);
  localparam logic [5:0] W6   = 6'(WIDTH);
  state_t           state_q, state_d;
  logic [5:0]       req_q, req_d, idx_q, idx_d;
  logic [3:0]       tick_q, tick_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             tick;
  assign tick = tick_q == TMAX;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    if (state_q == IDLE && in_valid) begin
      req_d   = ones_req > W6 ? W6 : ones_req;
      pat_d   = '0;
      idx_d   = '0;
      tick_d  = '0;
      state_d = BUILD;
    end else if (state_q == BUILD) begin
      tick_d = tick ? 4'd0 : tick_q + 4'd1;
      if (tick) begin
        // leading zeros go in first so the ones end up in the LSBs
        pat_d = {pat_q[WIDTH-2:0], idx_q >= W6 - req_q};
        idx_d = idx_q + 6'd1;
        state_d = idx_q == W6 - 6'd1 ? HOLD : BUILD;
      end
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      pat_q   <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == HOLD;
  assign busy        = state_q == BUILD;
  assign pattern_out = pat_q;
  assign zeros_out   = out_valid ? W6 - req_q : 6'd0;
  assign tick_count  = tick_q;
  assign bit_idx     = idx_q;
`ifdef ONES_PATTERN_SELFCHECK_EN
  logic [5:0] pop;
  logic       err_q;
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 6'(pat_q[i]);
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (state_q == HOLD && pop != req_q);
  end
  assign check_err = err_q;
`endif
endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb_ones_pattern_gen: directed checks of ones_pattern_gen at DIV=10, 1 and 2.
module tb_ones_pattern_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid[3], in_ready[3], out_valid[3], out_ready[3], busy[3];
  logic [5:0]  ones_req[3], zeros[3], bit_idx[3];
  logic [31:0] pattern[3];
  logic [3:0]  tick[3];
`ifdef ONES_PATTERN_SELFCHECK_EN
  logic        check_err[3];
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ones_pattern_gen #(.DIV(g == 0 ? 10 : (g == 1 ? 1 : 2)), .WIDTH(32)) u_dut (
      .clk_in(clk),
      .reset(rst),
      .in_valid(in_valid[g]),
      .in_ready(in_ready[g]),
      .ones_req(ones_req[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .pattern_out(pattern[g]),
      .zeros_out(zeros[g]),
      .busy(busy[g]),
      .tick_count(tick[g]),
      .bit_idx(bit_idx[g])
`ifdef ONES_PATTERN_SELFCHECK_EN
      ,
      .check_err(check_err[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int d, input int div, input logic [5:0] req,
                     input logic [31:0] exp_pat, input logic [5:0] exp_zeros,
                     input int hold, input bit poke);
    int n;
    bit stable;
    @(negedge clk);
    in_valid[d] = 1'b1;
    ones_req[d] = req;
    out_ready[d] = (hold == 0);
    check("accept_ready", 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    check("build_busy", 32'(busy[d]), 32'd1);
    check("build_tick0", 32'(tick[d]), 32'd0);
    check("build_idx0", 32'(bit_idx[d]), 32'd0);
    n = 0;
    while (!out_valid[d] && n < 600) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (poke) begin
        in_valid[d] = (n == 10);
        ones_req[d] = 6'd3;
        if (n == 10) check("busy_in_ready", 32'(in_ready[d]), 32'd0);
      end
    end
    in_valid[d] = 1'b0;
    check("latency", 32'(n), 32'(32 * div));
    check("pattern", pattern[d], exp_pat);
    check("zeros", 32'(zeros[d]), 32'(exp_zeros));
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        in_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!out_valid[d] || in_ready[d] || pattern[d] !== exp_pat) stable = 1'b0;
      end
      check("stall_stable", 32'(stable), 32'd1);
      in_valid[d] = 1'b0;
      out_ready[d] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("post_valid", 32'(out_valid[d]), 32'd0);
    check("post_ready", 32'(in_ready[d]), 32'd1);
    check("post_tick", 32'(tick[d]), 32'd0);
    check("post_keep", pattern[d], exp_pat);
  endtask

  initial begin
    int n, r;
    bit seen;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      out_ready[i] = 1'b1;
      ones_req[i] = 6'd0;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready[0]), 32'd1);
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_pattern", pattern[0], 32'd0);
    check("rst_zeros", 32'(zeros[0]), 32'd0);
    check("rst_tick", 32'(tick[0]), 32'd0);
    check("rst_idx", 32'(bit_idx[0]), 32'd0);
    rst = 1'b0;
    // reset in the middle of a build
    @(negedge clk);
    in_valid[0] = 1'b1;
    ones_req[0] = 6'd32;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    n = 0;
    while (bit_idx[0] != 6'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_idx", 32'(bit_idx[0]), 32'd5);
    check("mid_pattern", pattern[0], 32'h1f);
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(in_ready[0]), 32'd1);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_pattern", pattern[0], 32'd0);
    check("arst_tick", 32'(tick[0]), 32'd0);
    check("arst_idx", 32'(bit_idx[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("arst_no_valid", 32'(seen), 32'd0);
    run(0, 10, 6'd5, 32'h0000001f, 6'd27, 0, 0);
    run(1, 1, 6'd0, 32'h00000000, 6'd32, 0, 0);
    run(1, 1, 6'd32, 32'hffffffff, 6'd0, 0, 0);
    run(2, 2, 6'd45, 32'hffffffff, 6'd0, 0, 1);
    run(0, 10, 6'd17, 32'h0001ffff, 6'd15, 50, 0);
    run(2, 2, 6'd1, 32'h00000001, 6'd31, 0, 0);
    run(1, 1, 6'd31, 32'h7fffffff, 6'd1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 32);
      e = (r == 32) ? 32'hffffffff : ((32'h1 << r) - 32'h1);
      run(1, 1, 6'(r), e, 6'(32 - r), 0, 0);
      check("popcount", 32'($countones(pattern[1])), 32'(r));
`ifdef ONES_PATTERN_SELFCHECK_EN
      check("check_err", 32'(check_err[1]), 32'd0);
`endif
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ones_pattern_gen.md
Name: ones_pattern_gen

Overview:
- Inverse of the zero/one counter: takes a requested ones count (0..32) and builds the canonical 32-bit thermometer word with exactly that many ones in the LSBs.
- The word is assembled serially, one bit per divided-clock tick.
- Sits between the count producer and any consumer needing a reconstructed word.
- Valid/ready handshake on both input and output sides.

Parameters:
- DIV, 10, tick period in clk_in cycles; legal range 1..16.
- WIDTH, 32, output word width; fixed at 32, other values unsupported.

Ports:
- clk_in  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block accepts a request (IDLE only)
- ones_req  input  6  requested number of ones; values above 32 saturate to 32
- out_valid  output  1  pattern_out complete and stable
- out_ready  input  1  consumer accepts the pattern
- pattern_out  output  32  built word
- zeros_out  output  6  32 minus the latched ones count; valid with out_valid
- busy  output  1  high in BUILD
- tick_count  output  4  divider phase counter, 0..DIV-1
- bit_idx  output  6  bits shifted so far, 0..32

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, pattern_out=0, zeros_out=0, tick_count=0, bit_idx=0. An in-progress build is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch req=min(ones_req,32), clear pattern_out to 0, clear bit_idx and tick_count, then go to BUILD.
- State BUILD:
  - in_ready=0, busy=1.
  - tick_count increments every clk_in cycle and wraps DIV-1 -> 0.
  - A tick is the cycle where tick_count==DIV-1; with DIV=1, every cycle is a tick.
  - On each tick: pattern_out <= {pattern_out[30:0], b}, where b=0 while bit_idx < 32-req and b=1 otherwise; bit_idx increments.
  - On the tick where bit_idx becomes 32, go to HOLD.
- State HOLD:
  - out_valid=1, busy=0.
  - pattern_out is stable and equals (2^req)-1; zeros_out=32-req.
  - On out_valid&&out_ready, go to IDLE the next cycle with out_valid=0.
  - pattern_out keeps its last value in IDLE until the next acceptance.
- Latency: out_valid rises exactly 32*DIV clk_in cycles after the acceptance edge.
- Boundary cases:
  - req=0 -> 0x00000000, zeros_out=32.
  - req=32 -> 0xFFFFFFFF, zeros_out=0.
  - ones_req in 33..63 behaves as 32.
- in_valid while not in IDLE is ignored; it is not queued.
- out_ready while out_valid=0 has no effect.
- Back-to-back operation: a new request can be accepted one cycle after the HOLD handshake. No bubble-free chaining; no acceptance in the same cycle as the output handshake.
- tick_count holds 0 outside BUILD.

Optional Feature:
- Macro: ONES_PATTERN_SELFCHECK_EN.
- When defined:
  - Add output port check_err (1 bit, reset 0).
  - On entry to HOLD, a combinational popcount of pattern_out is compared with req.
  - On mismatch, check_err is set and is sticky until reset.
- When not defined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-build (DIV=10): assert reset during BUILD at bit_idx=5 -> immediately IDLE, in_ready=1, pattern_out=0, tick_count=0, out_valid never rises.
- DIV=10, ones_req=5, out_ready=1 -> out_valid at acceptance+320 cycles, pattern_out=0x0000001F, zeros_out=27; in_ready=1 the cycle after the handshake.
- ones_req=0 and then ones_req=32 (DIV=1) -> 0x00000000/zeros_out=32 and 0xFFFFFFFF/zeros_out=0, each after 32 cycles.
- ones_req=45 (DIV=2) -> treated as 32, pattern_out=0xFFFFFFFF after 64 cycles; in_valid pulses during BUILD are ignored (in_ready=0).
- Backpressure: ones_req=17, out_ready=0 for 50 cycles after out_valid -> pattern_out=0x0001FFFF held stable, out_valid high, no new acceptance; release -> IDLE next cycle.
- ONES_PATTERN_SELFCHECK_EN defined, six $random requests masked to 0..32 -> check_err stays 0; each pattern's popcount equals the request.
